// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM block.
//   pwm_mode_e        : counting mode of the shared timebase
//   PWM_WIDTH_DEFAULT : default counter/TOP/duty width
//   PWM_NCH_DEFAULT   : default channel count
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int unsigned PWM_WIDTH_DEFAULT = 8;
  localparam int unsigned PWM_NCH_DEFAULT   = 4;

endpackage

// File: rtl/pwm_multi_channel_compare.sv
// pwm_compare_ch: one PWM channel behind the shared timebase.
// Holds the duty shadow (written any time) and the active duty (loaded at
// the period boundary), compares against the counter and registers the
// polarity-adjusted output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : timebase enable; output holds while low
//   load       : period boundary tick; shadow -> active
//   wr_en      : shadow write strobe for this channel
//   wr_duty    : shadow write data
//   cnt        : shared counter value
//   cmp_down   : counter is in the descending half (centre mode, incl. TOP)
//   pwm_o      : registered PWM output
module pwm_compare_ch
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT,
  parameter logic        POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic [WIDTH-1:0] cnt,
  input  logic             cmp_down,
  output logic             pwm_o
);

  logic [WIDTH-1:0] duty_shadow;
  logic [WIDTH-1:0] duty_active;
  logic             raw;

  // On the descending half the match value itself is still active, so a
  // centre-aligned pulse is 2*duty ticks wide and symmetric about cnt==0;
  // duty>=TOP then covers the whole period.
  always_comb begin
    raw = (cnt < duty_active) | (cmp_down & (cnt == duty_active));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
      duty_active <= '0;
      pwm_o       <= POL;
    end else begin
      if (wr_en) duty_shadow <= wr_duty;
      // Non-blocking read: a same-cycle write lands at the next boundary.
      if (load)  duty_active <= duty_shadow;
      if (en)    pwm_o       <= raw ^ POL;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: N-channel PWM generator with a shared timebase.
// Programmable period (TOP), edge- or centre-aligned counting, per-channel
// duty and output polarity. TOP, mode and duty are double-buffered and
// switch only at period boundaries.
// Optional feature macro: PWM_PRESCALE_EN adds prescale_i and an 8-bit
// prescaler (tick every prescale_i+1 enabled cycles).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : timebase enable; low freezes counter and outputs
//   top_i      : period shadow, sampled at boundary
//   center_i   : 0 edge-aligned, 1 centre-aligned, sampled at boundary
//   cfg_we     : duty shadow write strobe
//   cfg_ch     : channel index for write (>= NCH ignored)
//   cfg_duty   : duty value for write
//   prescale_i : clock divider (PWM_PRESCALE_EN only)
//   pwm_o      : registered PWM outputs
//   cnt_o      : counter value
//   wrap_o     : pulse in the cycle the counter re-enters 0 at a boundary
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned     WIDTH    = PWM_WIDTH_DEFAULT,
  parameter int unsigned     NCH      = PWM_NCH_DEFAULT,
  parameter int unsigned     CHW      = 2,
  parameter logic [NCH-1:0]  POLARITY = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] top_i,
  input  logic             center_i,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_duty,
`ifdef PWM_PRESCALE_EN
  input  logic [7:0]       prescale_i,
`endif
  output logic [NCH-1:0]   pwm_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  logic             tick;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] top_act;
  logic             dir_down;
  logic             dir_nxt;
  pwm_mode_e        mode_act;
  logic             at_top;
  logic             boundary;
  logic             load;
  logic             cmp_down;

`ifdef PWM_PRESCALE_EN
  logic [7:0] presc_cnt;
  logic       presc_term;

  // >= rather than == so a live decrease of prescale_i cannot strand the
  // counter above the new terminal value.
  always_comb begin
    presc_term = (presc_cnt >= prescale_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= presc_term ? '0 : presc_cnt + 8'd1;
    end
  end

  always_comb begin
    tick = en & presc_term;
  end
`else
  always_comb begin
    tick = en;
  end
`endif

  always_comb begin
    at_top   = (cnt == top_act);
    boundary = 1'b0;
    if (top_act == '0) begin
      boundary = 1'b1;
    end else if (mode_act == PWM_EDGE) begin
      boundary = at_top;
    end else begin
      // TOP==1 never reaches cnt==1 while descending; its top is the boundary.
      boundary = (cnt == WIDTH'(1)) && (dir_down || (top_act == WIDTH'(1)));
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir_down;
    if (boundary) begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end else if (mode_act == PWM_EDGE) begin
      cnt_nxt = cnt + WIDTH'(1);
    end else if (dir_down || at_top) begin
      cnt_nxt = cnt - WIDTH'(1);
      dir_nxt = 1'b1;
    end else begin
      cnt_nxt = cnt + WIDTH'(1);
    end
  end

  always_comb begin
    load     = tick & boundary;
    cmp_down = (mode_act == PWM_CENTER) && (top_act != '0) && (dir_down || at_top);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dir_down <= 1'b0;
      top_act  <= '0;
      mode_act <= PWM_EDGE;
      wrap_o   <= 1'b0;
    end else begin
      wrap_o <= load;
      if (tick) begin
        cnt      <= cnt_nxt;
        dir_down <= dir_nxt;
        if (boundary) begin
          top_act  <= top_i;
          mode_act <= pwm_mode_e'(center_i);
        end
      end
    end
  end

  always_comb begin
    cnt_o = cnt;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_compare_ch #(
      .WIDTH (WIDTH),
      .POL   (POLARITY[i])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .load     (load),
      .wr_en    (cfg_we && (cfg_ch == CHW'(i))),
      .wr_duty  (cfg_duty),
      .cnt      (cnt),
      .cmp_down (cmp_down),
      .pwm_o    (pwm_o[i])
    );
  end

endmodule
